// File: rtl/jt900h_regs_pkg.sv
// Shared constants, types and decode helpers for the TLCS-900H register file.
// Region bases, width one-hot codes and byte-lane helpers live here so both ports agree.
package jt900h_regs_pkg;

    localparam int RFP_W = 2;
    localparam int NREGS = 20;  // 4 banks x 4 registers, then XIX, XIY, XIZ, XSP

    localparam logic [7:0] REG_BANK0 = 8'h00;
    localparam logic [7:0] REG_PREV  = 8'hD0;
    localparam logic [7:0] REG_CUR   = 8'hE0;
    localparam logic [7:0] REG_DED   = 8'hF0;

    localparam logic [2:0] W_BYTE = 3'b001;
    localparam logic [2:0] W_WORD = 3'b010;
    localparam logic [2:0] W_LONG = 3'b100;

    typedef logic [RFP_W-1:0] rfp_t;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } reg_sel_t;

    // Maps a byte address to a storage index; bank-relative regions use the given rfp.
    function automatic reg_sel_t reg_decode(input logic [7:0] a, input rfp_t rfp);
        reg_sel_t s;
        rfp_t     prev;
        prev  = rfp - 1'b1;
        s.hit = 1'b1;
        s.idx = '0;
        if (a[7:6] == REG_BANK0[7:6])     s.idx = {1'b0, a[5:2]};
        else if (a[7:4] == REG_PREV[7:4]) s.idx = {1'b0, prev, a[3:2]};
        else if (a[7:4] == REG_CUR[7:4])  s.idx = {1'b0, rfp, a[3:2]};
        else if (a[7:4] == REG_DED[7:4])  s.idx = {3'b100, a[3:2]};
        else                              s.hit = 1'b0;
        return s;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] w, input logic [1:0] lane);
        case (w)
            W_BYTE:  return 4'b0001 << lane;
            W_WORD:  return lane[1] ? 4'b1100 : 4'b0011;
            W_LONG:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicating right-aligned data across lanes lets byte_en pick the right copy.
    function automatic logic [31:0] lane_data(input logic [2:0] w, input logic [31:0] d);
        case (w)
            W_BYTE:  return {4{d[7:0]}};
            W_WORD:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/jt900h_regs_rd.sv
// One combinational read port: address decode, width alignment and zero-fill.
module jt900h_regs_rd
    import jt900h_regs_pkg::*;
(
    input  logic [7:0]             addr,
    input  logic [2:0]             width,
    input  rfp_t                   rfp,
    input  logic [NREGS-1:0][31:0] regs,
    output logic [31:0]            data
);

    reg_sel_t    sel;
    logic [31:0] word;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel  = reg_decode(addr, rfp);
        word = sel.hit ? regs[sel.idx] : 32'd0;
        data = 32'd0;
        case (width)
            W_BYTE:  data = {24'd0, word[{addr[1:0], 3'b000} +: 8]};
            W_WORD:  data = {16'd0, addr[1] ? word[31:16] : word[15:0]};
            W_LONG:  data = word;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/jt900h_regs.sv
// TLCS-900H register file: banked XWA..XHL, dedicated XIX..XSP, RFP, two read ports,
// delayed ALU write-back port and a memory-load write port that wins on overlap.
module jt900h_regs
    import jt900h_regs_pkg::*;
#(
    parameter logic [31:0] SP_RST = 32'h0000_0100
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  rd0_a,
    input  logic [7:0]  rd1_a,
    input  logic [2:0]  rd_w,
    output logic [31:0] op0,
    output logic [31:0] op1,
    input  logic [7:0]  wb_a,
    input  logic [2:0]  alu_we,
    input  logic [31:0] alu_dout,
    input  logic [2:0]  ld_we,
    input  logic [7:0]  ld_a,
    input  logic [31:0] ld_din,
    input  logic        rfp_ld,
    input  logic [1:0]  rfp_din,
    input  logic        rfp_inc,
    input  logic        rfp_dec,
    output logic [1:0]  rfp
);

    logic [NREGS-1:0][31:0] regs;
    logic [7:0]             wb_q;
    rfp_t                   rfp_q;

    reg_sel_t    alu_sel, ld_sel;
    logic [3:0]  alu_be, ld_be;
    logic [31:0] alu_lanes, ld_lanes;

    assign rfp = rfp_q;

    // Both write ports decode with the pre-edge rfp, so a same-edge RFP change is not seen.
    assign alu_sel   = reg_decode(wb_q, rfp_q);
    assign ld_sel    = reg_decode(ld_a, rfp_q);
    assign alu_be    = byte_en(alu_we, wb_q[1:0]);
    assign ld_be     = byte_en(ld_we, ld_a[1:0]);
    assign alu_lanes = lane_data(alu_we, alu_dout);
    assign ld_lanes  = lane_data(ld_we, ld_din);

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage array is reset because software relies on zeroed banks and XSP.
            regs            <= '0;
            regs[NREGS-1]   <= SP_RST;
            wb_q            <= '0;
            rfp_q           <= '0;
        end else if (cen) begin
            wb_q <= wb_a;
            if (rfp_ld)       rfp_q <= rfp_din;
            else if (rfp_inc) rfp_q <= rfp_q + 1'b1;
            else if (rfp_dec) rfp_q <= rfp_q - 1'b1;

            for (int i = 0; i < NREGS; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if (ld_sel.hit && ld_sel.idx == 5'(i) && ld_be[b])
                        regs[i][b*8 +: 8] <= ld_lanes[b*8 +: 8];
                    else if (alu_sel.hit && alu_sel.idx == 5'(i) && alu_be[b])
                        regs[i][b*8 +: 8] <= alu_lanes[b*8 +: 8];
                end
            end
        end
    end

    jt900h_regs_rd u_rd0 (
        .addr  (rd0_a),
        .width (rd_w),
        .rfp   (rfp_q),
        .regs  (regs),
        .data  (op0)
    );

    jt900h_regs_rd u_rd1 (
        .addr  (rd1_a),
        .width (rd_w),
        .rfp   (rfp_q),
        .regs  (regs),
        .data  (op1)
    );

endmodule

// File: tb/tb_jt900h_regs.sv
// Self-checking bench for jt900h_regs: directed scenarios plus randomized traffic
// against a byte-array reference model.
module tb_jt900h_regs;

    localparam logic [31:0] SP_RST = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [7:0]  rd0_a = '0, rd1_a = '0;
    logic [2:0]  rd_w = 3'b100;
    logic [31:0] op0, op1;
    logic [7:0]  wb_a = '0;
    logic [2:0]  alu_we = '0;
    logic [31:0] alu_dout = '0;
    logic [2:0]  ld_we = '0;
    logic [7:0]  ld_a = '0;
    logic [31:0] ld_din = '0;
    logic        rfp_ld = 1'b0;
    logic [1:0]  rfp_din = '0;
    logic        rfp_inc = 1'b0, rfp_dec = 1'b0;
    logic [1:0]  rfp;

    int n_cmp = 0;
    int n_err = 0;

    jt900h_regs #(.SP_RST(SP_RST)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .rd0_a(rd0_a), .rd1_a(rd1_a), .rd_w(rd_w), .op0(op0), .op1(op1),
        .wb_a(wb_a), .alu_we(alu_we), .alu_dout(alu_dout),
        .ld_we(ld_we), .ld_a(ld_a), .ld_din(ld_din),
        .rfp_ld(rfp_ld), .rfp_din(rfp_din), .rfp_inc(rfp_inc), .rfp_dec(rfp_dec),
        .rfp(rfp)
    );

    always #5 clk = ~clk;

    // Reference model: 20 registers stored as 80 little-endian bytes.
    logic [7:0] mb [0:79];
    int         m_rfp;
    logic [7:0] m_wb;

    function automatic int m_idx(input logic [7:0] a, input int r);
        int ai = int'(a);
        if (ai < 64)                return ai / 4;
        if (ai >= 208 && ai < 224)  return ((r + 3) % 4) * 4 + (ai % 16) / 4;
        if (ai >= 224 && ai < 240)  return r * 4 + (ai % 16) / 4;
        if (ai >= 240)              return 16 + (ai % 16) / 4;
        return -1;
    endfunction

    function automatic int nbytes(input logic [2:0] w);
        if (w == 3'b001) return 1;
        if (w == 3'b010) return 2;
        if (w == 3'b100) return 4;
        return 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a, input logic [2:0] w);
        int idx = m_idx(a, m_rfp);
        int n   = nbytes(w);
        int off;
        logic [31:0] r = '0;
        if (idx < 0 || n == 0) return '0;
        off = ((int'(a) % 4) / n) * n;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mb[idx*4 + off + k];
        return r;
    endfunction

    function automatic logic [31:0] m_reg(input int idx);
        return {mb[idx*4+3], mb[idx*4+2], mb[idx*4+1], mb[idx*4]};
    endfunction

    function automatic logic [7:0] reg_addr(input int idx);
        return (idx < 16) ? 8'(idx * 4) : 8'(240 + (idx - 16) * 4);
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [2:0] w, input logic [31:0] d, input int r);
        int idx = m_idx(a, r);
        int n   = nbytes(w);
        int off;
        if (idx < 0 || n == 0) return;
        off = ((int'(a) % 4) / n) * n;
        for (int k = 0; k < n; k++) mb[idx*4 + off + k] = d[8*k +: 8];
    endtask

    task automatic m_reset();
        for (int i = 0; i < 80; i++) mb[i] = 8'h00;
        for (int k = 0; k < 4; k++) mb[76 + k] = SP_RST[8*k +: 8];
        m_rfp = 0;
        m_wb  = 8'h00;
    endtask

    // Advances the model with the current inputs, then clocks the DUT.
    task automatic tick();
        if (cen) begin
            m_write(m_wb, alu_we, alu_dout, m_rfp);
            m_write(ld_a, ld_we, ld_din, m_rfp);
            m_wb = wb_a;
            if (rfp_ld)       m_rfp = int'(rfp_din);
            else if (rfp_inc) m_rfp = (m_rfp + 1) % 4;
            else if (rfp_dec) m_rfp = (m_rfp + 3) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cen = 1'b1; alu_we = '0; ld_we = '0;
        rfp_ld = 1'b0; rfp_inc = 1'b0; rfp_dec = 1'b0;
    endtask

    task automatic test_reset();
        rd_w = 3'b100;
        for (int i = 0; i < 20; i++) begin
            rd0_a = reg_addr(i);
            #1;
            n_cmp++;
            if (op0 !== ((i == 19) ? SP_RST : 32'd0)) begin
                n_err++;
                $display("FAIL reset_reg%0d: got %h expected %h", i, op0, (i == 19) ? SP_RST : 32'd0);
            end
        end
        n_cmp++;
        if (rfp !== 2'd0) begin n_err++; $display("FAIL reset_rfp: got %0d expected 0", rfp); end
    endtask

    task automatic test_writeback();
        idle();
        wb_a = 8'hE4; tick();
        alu_we = 3'b100; alu_dout = 32'h1234_5678; wb_a = 8'h00;
        rd0_a = 8'h04; rd_w = 3'b100; #1;
        n_cmp++;
        if (op0 !== 32'd0) begin n_err++; $display("FAIL no_bypass: got %h expected 00000000", op0); end
        tick(); idle();
        n_cmp++;
        if (op0 !== 32'h1234_5678) begin n_err++; $display("FAIL wb_long: got %h expected 12345678", op0); end
        rd1_a = 8'h06; rd_w = 3'b001; #1;
        n_cmp++;
        if (op1 !== 32'h0000_0034) begin n_err++; $display("FAIL rd_byte06: got %h expected 00000034", op1); end

        wb_a = 8'hE5; tick();
        alu_we = 3'b001; alu_dout = 32'h0000_00AA; tick(); idle();
        rd0_a = 8'h04; rd_w = 3'b100; #1;
        n_cmp++;
        if (op0 !== 32'h1234_AA78) begin n_err++; $display("FAIL wb_byte: got %h expected 1234aa78", op0); end
        rd1_a = 8'hE6; rd_w = 3'b010; #1;
        n_cmp++;
        if (op1 !== 32'h0000_1234) begin n_err++; $display("FAIL rd_wordE6: got %h expected 00001234", op1); end
    endtask

    task automatic test_rfp();
        idle();
        rfp_ld = 1'b1; rfp_din = 2'd2; tick(); idle();
        rfp_inc = 1'b1; tick(); tick(); idle();
        n_cmp++;
        if (rfp !== 2'd0) begin n_err++; $display("FAIL rfp_wrap_up: got %0d expected 0", rfp); end
        rfp_dec = 1'b1; tick(); idle();
        n_cmp++;
        if (rfp !== 2'd3) begin n_err++; $display("FAIL rfp_wrap_down: got %0d expected 3", rfp); end
        wb_a = 8'hD0; tick();
        alu_we = 3'b100; alu_dout = 32'hCAFE_BABE; tick(); idle();
        rd0_a = 8'h20; rd_w = 3'b100; #1;
        n_cmp++;
        if (op0 !== 32'hCAFE_BABE) begin n_err++; $display("FAIL prev_bank: got %h expected cafebabe", op0); end
    endtask

    task automatic test_overlap_cen();
        idle();
        wb_a = 8'hE0; tick();
        alu_we = 3'b100; alu_dout = 32'h1111_1111;
        ld_we = 3'b001; ld_a = 8'hE1; ld_din = 32'h0000_0022;
        tick(); idle();
        rd0_a = 8'hE0; rd_w = 3'b100; #1;
        n_cmp++;
        if (op0 !== 32'h1111_2211) begin n_err++; $display("FAIL ld_wins: got %h expected 11112211", op0); end
        cen = 1'b0; alu_we = 3'b100; alu_dout = 32'hFFFF_FFFF;
        ld_we = 3'b100; ld_a = 8'hE0; ld_din = 32'h0;
        rfp_inc = 1'b1;
        tick(); tick(); idle();
        n_cmp++;
        if (op0 !== 32'h1111_2211) begin n_err++; $display("FAIL cen_hold: got %h expected 11112211", op0); end
        n_cmp++;
        if (rfp !== 2'd3) begin n_err++; $display("FAIL cen_rfp: got %0d expected 3", rfp); end
    endtask

    task automatic test_rfp_race_unmapped();
        idle();
        rfp_ld = 1'b1; rfp_din = 2'd1; tick(); idle();
        wb_a = 8'hE8; tick();
        alu_we = 3'b100; alu_dout = 32'h0BAD_F00D; rfp_inc = 1'b1; tick(); idle();
        rd0_a = 8'h18; rd_w = 3'b100; #1;
        n_cmp++;
        if (op0 !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rfp_race: got %h expected 0badf00d", op0); end
        n_cmp++;
        if (rfp !== 2'd2) begin n_err++; $display("FAIL rfp_race_rfp: got %0d expected 2", rfp); end

        wb_a = 8'h50; tick();
        alu_we = 3'b100; alu_dout = 32'hDEAD_BEEF;
        ld_we = 3'b100; ld_a = 8'h9C; ld_din = 32'h5555_5555; tick(); idle();
        rd1_a = 8'h50; #1;
        n_cmp++;
        if (op1 !== 32'd0) begin n_err++; $display("FAIL unmapped_rd: got %h expected 00000000", op1); end
        for (int i = 0; i < 20; i++) begin
            rd0_a = reg_addr(i); #1;
            n_cmp++;
            if (op0 !== m_reg(i)) begin
                n_err++;
                $display("FAIL unmapped_wr_reg%0d: got %h expected %h", i, op0, m_reg(i));
            end
        end
    endtask

    task automatic test_reset_midop();
        idle();
        wb_a = 8'hF0; tick();
        rst = 1'b1; #2; rst = 1'b0;
        m_reset();
        alu_we = 3'b100; alu_dout = 32'h5A5A_5A5A; wb_a = 8'h00; tick(); idle();
        rd0_a = 8'hF0; rd1_a = 8'h00; rd_w = 3'b100; #1;
        n_cmp++;
        if (op0 !== 32'd0) begin n_err++; $display("FAIL rst_abort_xix: got %h expected 00000000", op0); end
        n_cmp++;
        if (op1 !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL rst_wbq_clear: got %h expected 5a5a5a5a", op1); end
        n_cmp++;
        if (rfp !== 2'd0) begin n_err++; $display("FAIL rst_rfp: got %0d expected 0", rfp); end
    endtask

    function automatic logic [7:0] pick_addr();
        int r = $urandom_range(0, 9);
        if (r < 4)  return 8'($urandom_range(8'h00, 8'h3F));
        if (r < 6)  return 8'($urandom_range(8'hD0, 8'hDF));
        if (r < 8)  return 8'($urandom_range(8'hE0, 8'hEF));
        if (r == 8) return 8'($urandom_range(8'hF0, 8'hFF));
        return 8'($urandom_range(8'h40, 8'hCF));
    endfunction

    function automatic logic [2:0] pick_w(input bit allow_none);
        int r = $urandom_range(allow_none ? 0 : 1, 3);
        return (r == 0) ? 3'b000 : 3'(1 << (r - 1));
    endfunction

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cen      = ($urandom_range(0, 99) < 85);
            wb_a     = pick_addr();
            alu_we   = pick_w(1'b1);
            alu_dout = $urandom;
            ld_we    = ($urandom_range(0, 2) == 0) ? pick_w(1'b0) : 3'b000;
            ld_a     = pick_addr();
            ld_din   = $urandom;
            rfp_ld   = ($urandom_range(0, 9) == 0);
            rfp_din  = 2'($urandom_range(0, 3));
            rfp_inc  = ($urandom_range(0, 6) == 0);
            rfp_dec  = ($urandom_range(0, 6) == 0);
            rd0_a    = pick_addr();
            rd1_a    = pick_addr();
            rd_w     = pick_w(1'b0);
            #1;
            n_cmp++;
            if (op0 !== m_read(rd0_a, rd_w)) begin
                n_err++;
                $display("FAIL rand_op0 c%0d a=%h w=%b: got %h expected %h", c, rd0_a, rd_w, op0, m_read(rd0_a, rd_w));
            end
            n_cmp++;
            if (op1 !== m_read(rd1_a, rd_w)) begin
                n_err++;
                $display("FAIL rand_op1 c%0d a=%h w=%b: got %h expected %h", c, rd1_a, rd_w, op1, m_read(rd1_a, rd_w));
            end
            tick();
            n_cmp++;
            if (int'(rfp) != m_rfp) begin
                n_err++;
                $display("FAIL rand_rfp c%0d: got %0d expected %0d", c, rfp, m_rfp);
            end
        end
        idle();
        rd_w = 3'b100;
        for (int i = 0; i < 20; i++) begin
            rd0_a = reg_addr(i); #1;
            n_cmp++;
            if (op0 !== m_reg(i)) begin
                n_err++;
                $display("FAIL rand_final_reg%0d: got %h expected %h", i, op0, m_reg(i));
            end
        end
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_writeback();
        test_rfp();
        test_overlap_cen();
        test_rfp_race_unmapped();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
